// File: rtl/memoria_pkg.sv
// rtl/memoria_pkg.sv - shared types and constants for the memoria write arbiter
// Contents: estado_t (NORMAL, VACIADO), default DEPTH/DATA_W, nivel_ancho() width helper.
package memoria_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        VACIADO = 1'b1
    } estado_t;

    localparam int DEPTH_DEF  = 16;
    localparam int DATA_W_DEF = 16;

    // Width able to hold 0..depth inclusive.
    function automatic int nivel_ancho(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rr_arbitro.sv
// rtl/rr_arbitro.sv - combinational round-robin grant with registered pointer
// Ports: clk, rst (async, active-high); elegible[NUM_REQ] candidate vector;
//        avanzar moves the pointer past the current winner;
//        valido = some candidate exists; indice = winner index.
module rr_arbitro
#(
    parameter int  NUM_REQ = 4,
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] elegible,
    input  logic               avanzar,
    output logic               valido,
    output logic [PW-1:0]      indice
);

    logic [PW-1:0] puntero;

    // Scan from the farthest offset back to the pointer so the candidate
    // closest to the pointer is the last one assigned and therefore wins.
    always_comb begin
        int idx;
        idx    = 0;
        valido = 1'b0;
        indice = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(puntero) + off) % NUM_REQ;
            if (elegible[PW'(idx)]) begin
                valido = 1'b1;
                indice = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            puntero <= '0;
        end else if (avanzar) begin
            puntero <= (int'(indice) == NUM_REQ - 1) ? '0 : indice + 1'b1;
        end
    end

endmodule

// File: rtl/memoria_arbitro.sv
// rtl/memoria_arbitro.sv - round-robin write arbiter and read sequencer for memoria
// Ports: req/dato_req/ack producer side; rd_req/dato_valido/dato_leido consumer side;
//        vaciar flush pulse; nivel occupancy; fifo_* drive/observe memoria;
//        error sticky misuse flag. Optional macro MEMORIA_ARB_CNT_EN adds
//        cnt_escrituras and cnt_bloqueos.
module memoria_arbitro
    import memoria_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_W-1:0]     dato_req,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          rd_req,
    output logic                          dato_valido,
    output logic [DATA_W-1:0]             dato_leido,
    input  logic                          vaciar,
    output logic [nivel_ancho(DEPTH)-1:0] nivel,
    output logic                          fifo_wr_en,
    output logic                          fifo_rd_en,
    output logic [DATA_W-1:0]             fifo_dato_in,
    input  logic [DATA_W-1:0]             fifo_dato_out,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    output logic                          error
`ifdef MEMORIA_ARB_CNT_EN
    ,
    output logic [15:0]                   cnt_escrituras,
    output logic [15:0]                   cnt_bloqueos
`endif
);

    localparam int              NW    = nivel_ancho(DEPTH);
    localparam int              PW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NW-1:0]   LLENO = NW'(DEPTH);

    estado_t       estado;
    logic          lectura_normal;
    logic          modo_vaciado;
    logic          hay_elegible;
    logic          concede;
    logic          lee;
    logic [PW-1:0] ganador;

    // The vaciar cycle already behaves as a flush so no word slips in or
    // gets marked valid on the edge that starts the drain.
    assign modo_vaciado = (estado == VACIADO) || vaciar;
    // nivel counts words at issue time, so it already includes every write in flight.
    assign concede      = hay_elegible && !modo_vaciado && (nivel < LLENO);
    assign lee          = (nivel != '0) && (modo_vaciado || rd_req);
    assign dato_leido   = fifo_dato_out;

    rr_arbitro #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk      (clk),
        .rst      (rst),
        .elegible (req & ~ack),
        .avanzar  (concede),
        .valido   (hay_elegible),
        .indice   (ganador)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado         <= NORMAL;
            ack            <= '0;
            fifo_wr_en     <= 1'b0;
            fifo_dato_in   <= '0;
            fifo_rd_en     <= 1'b0;
            lectura_normal <= 1'b0;
            dato_valido    <= 1'b0;
            nivel          <= '0;
            error          <= 1'b0;
        end else begin
            ack        <= '0;
            fifo_wr_en <= concede;
            if (concede) begin
                ack[ganador] <= 1'b1;
                fifo_dato_in <= dato_req[int'(ganador)*DATA_W +: DATA_W];
            end

            // Flush reads never produce dato_valido.
            fifo_rd_en     <= lee;
            lectura_normal <= lee && !modo_vaciado;
            dato_valido    <= lectura_normal;

            case ({concede, lee})
                2'b10:   nivel <= nivel + 1'b1;
                2'b01:   nivel <= nivel - 1'b1;
                default: nivel <= nivel;
            endcase

            error <= error | (fifo_wr_en & fifo_full) | (fifo_rd_en & fifo_empty);

            case (estado)
                NORMAL:  if (vaciar) estado <= VACIADO;
                VACIADO: if ((nivel == '0) && !fifo_rd_en) estado <= NORMAL;
            endcase
        end
    end

`ifdef MEMORIA_ARB_CNT_EN
    logic bloqueo;
    assign bloqueo = hay_elegible && !modo_vaciado && (nivel >= LLENO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_escrituras <= '0;
            cnt_bloqueos   <= '0;
        end else begin
            if (concede && (cnt_escrituras != 16'hFFFF)) cnt_escrituras <= cnt_escrituras + 16'd1;
            if (bloqueo && (cnt_bloqueos != 16'hFFFF))   cnt_bloqueos   <= cnt_bloqueos + 16'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_memoria_arbitro.sv
// tb/tb_memoria_arbitro.sv - directed self-checking bench for memoria_arbitro
module tb_memoria_arbitro;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] dato_req;
    logic [3:0]  ack;
    logic        rd_req;
    logic        dato_valido;
    logic [15:0] dato_leido;
    logic        vaciar;
    logic [4:0]  nivel;
    logic        fifo_wr_en;
    logic        fifo_rd_en;
    logic [15:0] fifo_dato_in;
    logic [15:0] fifo_dato_out;
    logic        fifo_full;
    logic        fifo_empty;
    logic        error;
`ifdef MEMORIA_ARB_CNT_EN
    logic [15:0] cnt_escrituras;
    logic [15:0] cnt_bloqueos;
`endif

    logic [15:0] dato_p [4];
    int          seq_p  [4];
    logic        fuerza_lleno;
    logic        full_r;
    logic [15:0] fifo_q [$];

    int total   = 0;
    int pasados = 0;

    assign dato_req  = {dato_p[3], dato_p[2], dato_p[1], dato_p[0]};
    assign fifo_full = full_r | fuerza_lleno;

    memoria_arbitro #(.NUM_REQ(4), .DATA_W(16), .DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .dato_req      (dato_req),
        .ack           (ack),
        .rd_req        (rd_req),
        .dato_valido   (dato_valido),
        .dato_leido    (dato_leido),
        .vaciar        (vaciar),
        .nivel         (nivel),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_dato_in  (fifo_dato_in),
        .fifo_dato_out (fifo_dato_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .error         (error)
`ifdef MEMORIA_ARB_CNT_EN
        ,
        .cnt_escrituras(cnt_escrituras),
        .cnt_bloqueos  (cnt_bloqueos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memoria: 16 words, registered read data and flags.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q.delete();
            fifo_dato_out <= '0;
            full_r        <= 1'b0;
            fifo_empty    <= 1'b1;
        end else begin
            int n;
            if (fifo_rd_en && fifo_q.size() > 0) fifo_dato_out <= fifo_q.pop_front();
            if (fifo_wr_en && fifo_q.size() < 16) fifo_q.push_back(fifo_dato_in);
            n = fifo_q.size();
            full_r     <= (n == 16);
            fifo_empty <= (n == 0);
        end
    end

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        total++;
        if (obs === esp) pasados++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reinicio;
        rst          = 1'b1;
        req          = '0;
        rd_req       = 1'b0;
        vaciar       = 1'b0;
        fuerza_lleno = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dato_p[i] = '0;
            seq_p[i]  = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Producers present their next word in the cycle they see ack.
    task automatic avanza_productores;
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                seq_p[i]++;
                dato_p[i] = 16'(16'h1000 * (i + 1) + seq_p[i]);
            end
        end
    endtask

    initial begin
        logic [3:0] esp_ack;

        // Reset state
        reinicio();
        chequear("rst_ack", ack, 0);
        chequear("rst_wr_en", fifo_wr_en, 0);
        chequear("rst_rd_en", fifo_rd_en, 0);
        chequear("rst_valido", dato_valido, 0);
        chequear("rst_nivel", nivel, 0);
        chequear("rst_error", error, 0);
        chequear("rst_dato_in", fifo_dato_in, 0);
        chequear("rst_leido", dato_leido, 0);

        // Single requester: one word every two cycles
        req       = 4'b0001;
        dato_p[0] = 16'h0011;
        for (int k = 0; k < 6; k++) begin
            tick();
            chequear("uno_ack", ack, (k % 2 == 0) ? 1 : 0);
            chequear("uno_wr_en", fifo_wr_en, (k % 2 == 0) ? 1 : 0);
            chequear("uno_nivel", nivel, k / 2 + 1);
            if (k % 2 == 0) chequear("uno_dato", fifo_dato_in, 16'h0011);
        end

        // Four requesters: round robin, one word per cycle, stops at DEPTH
        reinicio();
        for (int i = 0; i < 4; i++) dato_p[i] = 16'(16'h1000 * (i + 1));
        req = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            tick();
            esp_ack = 4'b0001 << (k % 4);
            chequear("rr_ack", ack, esp_ack);
            chequear("rr_wr_en", fifo_wr_en, 1);
            chequear("rr_dato", fifo_dato_in, 16'h1000 * (k % 4 + 1) + k / 4);
            chequear("rr_nivel", nivel, k + 1);
            avanza_productores();
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            chequear("lleno_ack", ack, 0);
            chequear("lleno_wr_en", fifo_wr_en, 0);
            chequear("lleno_nivel", nivel, 16);
            chequear("lleno_error", error, 0);
        end
`ifdef MEMORIA_ARB_CNT_EN
        chequear("cnt_escrituras", cnt_escrituras, 16);
        chequear("cnt_bloqueos", cnt_bloqueos, 2);
`endif

        // Three reads from a full FIFO, data in write order
        req    = 4'b0000;
        rd_req = 1'b1;
        tick();
        chequear("rd0_rd_en", fifo_rd_en, 1);
        chequear("rd0_valido", dato_valido, 0);
        chequear("rd0_nivel", nivel, 15);
        tick();
        chequear("rd1_rd_en", fifo_rd_en, 1);
        chequear("rd1_valido", dato_valido, 1);
        chequear("rd1_dato", dato_leido, 16'h1000);
        chequear("rd1_nivel", nivel, 14);
        tick();
        chequear("rd2_rd_en", fifo_rd_en, 1);
        chequear("rd2_valido", dato_valido, 1);
        chequear("rd2_dato", dato_leido, 16'h2000);
        chequear("rd2_nivel", nivel, 13);
        rd_req = 1'b0;
        tick();
        chequear("rd3_rd_en", fifo_rd_en, 0);
        chequear("rd3_valido", dato_valido, 1);
        chequear("rd3_dato", dato_leido, 16'h3000);
        chequear("rd3_nivel", nivel, 13);
        tick();
        chequear("rd4_valido", dato_valido, 0);
        chequear("rd4_nivel", nivel, 13);
        chequear("rd4_error", error, 0);

        // Flush with nivel=5 while two requesters keep asking
        reinicio();
        dato_p[0] = 16'h00A0;
        dato_p[1] = 16'h00B0;
        req       = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            tick();
            chequear("pre_ack", ack, (k % 2 == 0) ? 4'b0001 : 4'b0010);
            chequear("pre_nivel", nivel, k + 1);
        end
        vaciar = 1'b1;
        for (int j = 0; j < 7; j++) begin
            tick();
            vaciar = 1'b0;
            chequear("vac_rd_en", fifo_rd_en, (j <= 4) ? 1 : 0);
            chequear("vac_nivel", nivel, (j <= 4) ? 4 - j : 0);
            chequear("vac_ack", ack, 0);
            chequear("vac_valido", dato_valido, 0);
        end
        tick();
        chequear("post_ack", ack, 4'b0010);
        chequear("post_wr_en", fifo_wr_en, 1);
        chequear("post_nivel", nivel, 1);
        chequear("post_error", error, 0);

        // Write issued against a full FIFO sets the sticky error
        reinicio();
        fuerza_lleno = 1'b1;
        dato_p[0]    = 16'h0055;
        req          = 4'b0001;
        tick();
        chequear("err_ack", ack, 4'b0001);
        chequear("err_previo", error, 0);
        req = 4'b0000;
        tick();
        fuerza_lleno = 1'b0;
        chequear("err_set", error, 1);
        repeat (2) tick();
        chequear("err_sticky", error, 1);

        // Asynchronous reset in the middle of a write burst
        reinicio();
        for (int i = 0; i < 4; i++) dato_p[i] = 16'(16'h5000 + i);
        req    = 4'b1111;
        rd_req = 1'b1;
        repeat (3) tick();
        chequear("mid_wr_en", fifo_wr_en, 1);
        #2;
        rst = 1'b1;
        #1;
        chequear("arst_ack", ack, 0);
        chequear("arst_wr_en", fifo_wr_en, 0);
        chequear("arst_dato_in", fifo_dato_in, 0);
        chequear("arst_rd_en", fifo_rd_en, 0);
        chequear("arst_valido", dato_valido, 0);
        chequear("arst_nivel", nivel, 0);
        chequear("arst_error", error, 0);
        chequear("arst_leido", dato_leido, 0);
`ifdef MEMORIA_ARB_CNT_EN
        chequear("arst_cnt_esc", cnt_escrituras, 0);
        chequear("arst_cnt_bloq", cnt_bloqueos, 0);
`endif
        tick();
        rst = 1'b0;

        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end

endmodule

// File: doc/memoria_arbitro.md
# memoria_arbitro

Write-side round-robin arbiter and read-side sequencer for the 16-bit `memoria` FIFO. It shares the FIFO write port between NUM_REQ producers and serves one consumer through a read-request/valid handshake. It keeps its own occupancy count, so it never depends on the FIFO's registered `full` and `empty` flags. It sits directly between the producer blocks and `memoria`, and drives all of that FIFO's control inputs.

## Interface
- NUM_REQ, 4: number of write requesters, 2..8
- DATA_W, 16: data width, must equal `memoria` width
- DEPTH, 16: `memoria` capacity in words
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request, level
- dato_req  in  NUM_REQ*DATA_W  requester data; slice i belongs to req[i]
- ack  out  NUM_REQ  one-cycle pulse: the word from requester i was issued to the FIFO
- rd_req  in  1  consumer wants a word, level
- dato_valido  out  1  `dato_leido` is valid this cycle
- dato_leido  out  DATA_W  combinational pass-through of `fifo_dato_out`
- vaciar  in  1  flush request, pulse
- nivel  out  $clog2(DEPTH+1)  current occupancy
- fifo_wr_en / fifo_rd_en  out  1  FIFO controls
- fifo_dato_in  out  DATA_W  FIFO write data
- fifo_dato_out  in  DATA_W  FIFO read data
- fifo_full / fifo_empty  in  1  FIFO flags, used only for error detection
- error  out  1  sticky error: a write was issued while `fifo_full`=1, or a read was issued while `fifo_empty`=1; cleared only by reset

## Operation
- Reset values: every output is 0. `nivel`=0, FSM=NORMAL, round-robin pointer=0.
- FSM states: NORMAL and VACIADO.
  - NORMAL -> VACIADO on `vaciar`.
  - VACIADO -> NORMAL once `nivel`=0 and no read is outstanding.
- Write arbitration (NORMAL only):
  - Eligible requesters: req[i]=1 and ack[i]=0. The mask stops a requester from being granted twice for the same word.
  - Among eligible requesters, the first one at or after the pointer wins.
  - A grant happens only if `nivel` + writes in flight < DEPTH.
  - On a grant, the same edge registers `fifo_wr_en`=1, `fifo_dato_in`=dato_req slice, and ack[winner]=1. The pointer becomes winner+1 mod NUM_REQ.
- Requester rule: a requester holds req and data stable until it sees ack. In the ack cycle it either drops req or presents its next word.
- Read path (NORMAL):
  - If rd_req=1 and `nivel`>0 at an edge, register `fifo_rd_en`=1 for one cycle.
  - `dato_valido` is registered 1 on the following edge.
  - The consumer keeps rd_req high to stream words.
- VACIADO:
  - Writes are blocked and every req is ignored (no ack).
  - `fifo_rd_en`=1 every cycle while `nivel`>0.
  - `dato_valido` stays 0.
- `nivel` update: +1 per issued write, -1 per issued read; a simultaneous write and read leave it unchanged. `nivel` never exceeds DEPTH and never goes below 0.

## Timing
- Write latency: req sampled at edge k -> ack and `fifo_wr_en` high in cycle k..k+1 -> data stored in `memoria` at edge k+1.
- Read latency: rd_req sampled at edge k -> `fifo_rd_en` in cycle k..k+1 -> `dato_valido` in cycle k+1..k+2.
- Write throughput:
  - 1 word/cycle when at least 2 requesters are active.
  - 1 word per 2 cycles with a single requester, because of the ack mask.
- Simultaneous write and read with `nivel`=DEPTH: the read is issued and the write waits one cycle. Grant decisions use the registered `nivel`.
- `vaciar` while already in VACIADO is ignored.
- Asynchronous `rst` mid-transfer:
  - All outputs clear immediately and in-flight transfers are abandoned.
  - `memoria` shares `rst`, so the counter and FIFO stay consistent.

## Configuration
- MEMORIA_ARB_CNT_EN defined:
  - Adds output `cnt_escrituras[15:0]`: issued writes, saturating at 16'hFFFF.
  - Adds output `cnt_bloqueos[15:0]`: cycles with an eligible request but no grant because of occupancy, saturating.
  - Both counters reset to 0.
- MEMORIA_ARB_CNT_EN not defined: neither port nor the counter logic exists.

## Structure
- `memoria_pkg`: FSM state enum (NORMAL, VACIADO), default DEPTH/DATA_W constants, and a function computing the width of `nivel`.
- Sub-module `rr_arbitro`: combinational round-robin grant over an eligibility vector plus the registered pointer, parameterised by NUM_REQ. It is instantiated once.

## Test plan
- Reset, then req=4'b0001 holding 16'h0011: ack[0] pulses every 2nd cycle, `fifo_wr_en` follows the same pattern, `nivel` increments to 1, 2, ...
- req=4'b1111 held with distinct data: ack order 0,1,2,3,0,... with one write per cycle; after 16 writes `nivel`=16, all acks stop, and `error` stays 0.
- FIFO full, then rd_req=1 for 3 cycles: 3 `fifo_rd_en` pulses, `dato_valido` one cycle later each time carrying the first three words in write order, and `nivel`=13.
- `nivel`=5, pulse `vaciar` with req=4'b0011: 5 reads, no acks, `dato_valido`=0, `nivel`=0, FSM returns to NORMAL, and writes resume the next cycle.
- Assert rst mid-stream while `fifo_wr_en`=1: all outputs are 0 within the same cycle and `nivel`=0; with MEMORIA_ARB_CNT_EN defined, `cnt_bloqueos` counts cycles while full with requests pending.
